// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential shift-and-add multiplier: FSM state encoding and default operand width.
package seq_mul_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/add_w.sv
// WIDTH-bit ripple-carry adder chained from fulladd cells; combinational, no handshake.
module add_w #(
  parameter int WIDTH = 4
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fulladd u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/fulladd.sv
// One-bit full adder cell, purely combinational; used as the ripple element of add_w.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_mul_ctrl.sv
// Unsigned shift-and-add multiplier sharing one add_w over WIDTH iterations; done pulses WIDTH+1
// cycles after accept; start is only sampled in IDLE, requests while busy are dropped, not queued.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign addend = q_q[0] ? m_q : '0;

  add_w #(
    .WIDTH (WIDTH)
  ) u_add (
    .cin  (1'b0),
    .a    (acc_q),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          count_d = '0;
        end
      end
      RUN: begin
        // The carry register would always read 0 after the shift, so cout feeds A's MSB directly.
        acc_d   = {cout, sum[WIDTH-1:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = {acc_d, q_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Sequential unsigned shift-and-add multiplier controller that time-shares one WIDTH-bit ripple adder (fulladd cells) across WIDTH iterations.
- Replaces a wide combinational array multiplier: one adder plus a small FSM, accumulator and shift register.
- Sits beside the 4-bit add/subtract datapath. Requester uses a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH bits. Legal range 2..16.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only in IDLE.
- a  in  WIDTH  multiplicand. Captured on accepted start.
- b  in  WIDTH  multiplier. Captured on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result register. Holds until the next accepted start completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal M, A, Q, C and count all 0.
  - Deassertion is synchronised by the reset structure outside this block.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while count < WIDTH-1; RUN -> DONE when count == WIDTH-1 (after that iteration).
  - DONE -> IDLE unconditionally.
- Accept (IDLE, start=1, cycle 0):
  - M<=a; Q<=b; A<=0; C<=0; count<=0.
  - a/b changes after cycle 0 have no effect.
- RUN iteration (cycles 1..WIDTH):
  - {C,S} = A + (Q[0] ? M : 0) via the shared adder, cin tied 0.
  - Then {C,A,Q} <= {C,S,Q} >> 1, i.e. {0,C,S[W-1:1]} and {S[0],Q[W-1:1]}.
  - count<=count+1.
  - Carry-out is never lost: it shifts into A[W-1].
- DONE (cycle WIDTH+1): done=1; product<={A,Q} registered on entry to DONE, so it is valid in the same cycle done is high.
- Latency: done asserts exactly WIDTH+1 cycles after the accept cycle. Throughput is one result per WIDTH+2 cycles.
- busy: 1 in RUN and DONE; 0 in IDLE. Rises the cycle after accept.
- start while busy (RUN or DONE): ignored, not queued. A start held high through DONE is accepted in the following IDLE cycle.
- Reset mid-operation: immediate abort to reset values. No done pulse; product cleared to 0.
- Width rule: max result (2^W-1)^2 < 2^(2W), so no overflow by construction.
- Zero operands: still take the full WIDTH iterations (no early exit).

Decomposition:
- Shared package seq_mul_pkg:
  - state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - default WIDTH constant
- One natural sub-module: add_w, a WIDTH-parameterised ripple adder (cin, a, b, sum, cout) built from the existing fulladd cell; instantiated once.
- FSM, counter and shift registers stay in seq_mul_ctrl.

Test Plan:
- Reset released, no start -> busy=0, done=0, product=0x00 indefinitely.
- a=13, b=11, start pulse -> busy high next cycle; done single pulse exactly 5 cycles after accept; product=0x8F (143).
- a=15, b=15 -> product=0xE1 (225). Confirms carry-out shifted in on every iteration.
- a=0, b=9 and a=9, b=0 -> product=0x00; done still at +5 cycles.
- start held high continuously with a=3, b=5 -> first result 15 at +5; second accept in the cycle after done; no accept during RUN/DONE; period 6 cycles.
- Accept a=7, b=6, then drive rst_n=0 at cycle 3 -> busy=0 and product=0 immediately; no done. After release, new start a=2, b=3 -> product=6.
